// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
// The optional command watchdog is enabled by defining I2C_SEQ_TIMEOUT_EN.
package i2c_seq_pkg;

  // Top-level sequencer states; each command state is split into ISSUE/WAIT phases.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_W,
    ST_REG,
    ST_WDATA,
    ST_ADDR_R,
    ST_READ,
    ST_STOP,
    ST_FIN
  } state_t;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  // Completion status reported with done.
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // R/W bit appended to the 7-bit slave address.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Request fields captured when a transaction is accepted.
  typedef struct packed {
    logic       op;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [2:0] rd_len;
  } req_t;

  // Address byte as it appears on the bus.
  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_seq_wdog.sv
// Per-command watchdog: counts WAIT cycles and flags expiry after TIMEOUT_CYCLES.
// Only instantiated when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value during the last allowed WAIT cycle (value k-1 in WAIT cycle k).
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter: cleared in ISSUE, advances in WAIT, saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/i2c_seq_ctrl.sv
// I2C register-write / burst-read sequencer driving a byte-level I2C master.
// Define I2C_SEQ_TIMEOUT_EN to add a per-command watchdog (err=10 on expiry).
module i2c_seq_ctrl
  import i2c_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       op,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic [2:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_write,
  output logic       m_read,
  output logic [7:0] m_data_in,
  output logic       m_ack_in,
  input  logic       m_done,
  input  logic       m_busy,
  input  logic       m_ack_err,
  input  logic [7:0] m_data_out
);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  req_t       cfg_q;
  logic [2:0] byte_cnt_q;

  logic       accept;
  logic       capture;
  logic       last_byte;
  logic       err_set;
  logic [1:0] err_code;
  logic       timeout;
  logic       is_cmd;
  logic       is_write;
  state_t     nxt;

  assign last_byte = (byte_cnt_q == cfg_q.rd_len);

`ifdef I2C_SEQ_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (phase_q == PH_ISSUE);
  assign wd_enable = (phase_q == PH_WAIT) && is_cmd;

  i2c_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State and phase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic and Moore command outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    accept    = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    err_code  = ERR_OK;
    is_cmd    = 1'b0;
    is_write  = 1'b0;
    nxt       = state_q;
    m_start   = 1'b0;
    m_stop    = 1'b0;
    m_write   = 1'b0;
    m_read    = 1'b0;
    m_data_in = 8'h00;
    m_ack_in  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && !m_busy) begin
          accept  = 1'b1;
          state_d = ST_ADDR_W;
          phase_d = PH_ISSUE;
        end
      end
      ST_ADDR_W: begin
        is_cmd    = 1'b1;
        is_write  = 1'b1;
        m_start   = (phase_q == PH_ISSUE);
        m_write   = (phase_q == PH_ISSUE);
        m_data_in = addr_byte(cfg_q.dev_addr, RW_WRITE);
        nxt       = ST_REG;
      end
      ST_REG: begin
        is_cmd    = 1'b1;
        is_write  = 1'b1;
        m_write   = (phase_q == PH_ISSUE);
        m_data_in = cfg_q.reg_addr;
        nxt       = cfg_q.op ? ST_ADDR_R : ST_WDATA;
      end
      ST_WDATA: begin
        is_cmd    = 1'b1;
        is_write  = 1'b1;
        m_write   = (phase_q == PH_ISSUE);
        m_data_in = cfg_q.wdata;
        nxt       = ST_STOP;
      end
      ST_ADDR_R: begin
        is_cmd    = 1'b1;
        is_write  = 1'b1;
        m_start   = (phase_q == PH_ISSUE);
        m_write   = (phase_q == PH_ISSUE);
        m_data_in = addr_byte(cfg_q.dev_addr, RW_READ);
        nxt       = ST_READ;
      end
      ST_READ: begin
        is_cmd   = 1'b1;
        m_read   = (phase_q == PH_ISSUE);
        // Held through both phases so the master sees a stable ACK/NACK choice.
        m_ack_in = last_byte;
        capture  = (phase_q == PH_WAIT) && m_done;
        nxt      = last_byte ? ST_STOP : ST_READ;
      end
      ST_STOP: begin
        is_cmd = 1'b1;
        m_stop = (phase_q == PH_ISSUE);
        nxt    = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        phase_d = PH_ISSUE;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_ISSUE;
      end
    endcase

    // Shared ISSUE -> WAIT -> next-command sequencing for all command states.
    if (is_cmd) begin
      if (phase_q == PH_ISSUE) begin
        phase_d = PH_WAIT;
      end else if (m_done) begin
        phase_d = PH_ISSUE;
        if (is_write && m_ack_err) begin
          state_d  = ST_STOP;
          err_set  = 1'b1;
          err_code = ERR_NACK;
        end else begin
          state_d = nxt;
        end
      end else if (timeout) begin
        phase_d  = PH_ISSUE;
        err_set  = 1'b1;
        err_code = ERR_TIMEOUT;
        // A stuck STOP cannot be retried; finish the transaction directly.
        state_d  = (state_q == ST_STOP) ? ST_FIN : ST_STOP;
      end
    end
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done = (state_q == ST_FIN);

  // Request capture, byte counter, status and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q      <= '0;
      byte_cnt_q <= 3'd0;
      err        <= ERR_OK;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      rd_valid <= capture;
      rd_last  <= capture && last_byte;
      if (capture) begin
        rd_data <= m_data_out;
      end
      if (accept) begin
        cfg_q      <= '{op: op, dev_addr: dev_addr, reg_addr: reg_addr,
                        wdata: wdata, rd_len: rd_len};
        byte_cnt_q <= 3'd0;
        err        <= ERR_OK;
      end else begin
        if (capture && !last_byte) begin
          byte_cnt_q <= byte_cnt_q + 3'd1;
        end
        if (err_set) begin
          err <= err_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Self-checking bench for i2c_seq_ctrl: table-driven transactions against a
// behavioural I2C master/slave responder, plus hand-written corner sequences.
// The timeout sequence runs only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       op;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic [2:0] rd_len;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_last;
  logic       m_start;
  logic       m_stop;
  logic       m_write;
  logic       m_read;
  logic [7:0] m_data_in;
  logic       m_ack_in;
  logic       m_done;
  logic       m_busy;
  logic       m_ack_err;
  logic [7:0] m_data_out;

  always #5 clk = ~clk;

  i2c_seq_ctrl #(.TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op        (op),
    .dev_addr  (dev_addr),
    .reg_addr  (reg_addr),
    .wdata     (wdata),
    .rd_len    (rd_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .m_start   (m_start),
    .m_stop    (m_stop),
    .m_write   (m_write),
    .m_read    (m_read),
    .m_data_in (m_data_in),
    .m_ack_in  (m_ack_in),
    .m_done    (m_done),
    .m_busy    (m_busy),
    .m_ack_err (m_ack_err),
    .m_data_out(m_data_out)
  );

  // Transaction vector: request, slave behaviour, and expected observations.
  typedef struct {
    logic        op;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wd;
    logic [2:0]  len;
    int          nack_at;     // write command index (1-based) the slave NACKs, 0 = none
    logic [63:0] slave;       // read bytes, first byte in [63:56]
    int          exp_wr;
    logic [23:0] exp_wr_acc;
    logic [2:0]  exp_start;
    int          exp_rd;
    logic [63:0] exp_rd_acc;
    logic [7:0]  exp_ack;
    logic [7:0]  exp_last;
    logic [1:0]  exp_err;
  } vec_t;

  localparam int NVEC = 7;
  vec_t tbl [NVEC];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Responder configuration.
  int          nack_cfg     = 0;
  int          withhold_cfg = 0;
  logic [63:0] slave_cfg    = '0;

  // Observation logs.
  int          wr_cnt, rd_cmd_cnt, stop_cnt, rv_cnt, done_cnt;
  int          ack_unstable, busy_bad;
  int          reg_cycle, stop_cycle;
  logic [23:0] wr_acc;
  logic [2:0]  start_acc;
  logic [63:0] rd_acc;
  logic [7:0]  ack_acc, last_acc;
  logic [1:0]  err_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [63:0] outs();
    return {37'd0, busy, done, err, rd_data, rd_valid, rd_last,
            m_start, m_stop, m_write, m_read, m_data_in, m_ack_in};
  endfunction

  task automatic clear_logs();
    wr_cnt = 0; rd_cmd_cnt = 0; stop_cnt = 0; rv_cnt = 0; done_cnt = 0;
    ack_unstable = 0; busy_bad = 0; reg_cycle = 0; stop_cycle = 0;
    wr_acc = '0; start_acc = '0; rd_acc = '0; ack_acc = '0; last_acc = '0;
    err_at_done = 2'b11;
  endtask

  // Behavioural master+slave: logs each command and answers with m_done after 2 WAIT cycles.
  initial begin : responder
    logic       nack, hold, is_rd, ack_exp;
    logic [7:0] cur_byte;
    m_done = 1'b0; m_ack_err = 1'b0; m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (reset && (m_write || m_read || m_stop)) begin
        nack = 1'b0; hold = 1'b0; cur_byte = 8'h00;
        is_rd = m_read; ack_exp = m_ack_in;
        if (m_write) begin
          wr_cnt++;
          wr_acc    = {wr_acc[15:0], m_data_in};
          start_acc = {start_acc[1:0], m_start};
          nack      = (wr_cnt == nack_cfg);
          hold      = (wr_cnt == withhold_cfg);
          if (wr_cnt == 2) reg_cycle = cyc;
        end
        if (m_read) begin
          if (rd_cmd_cnt < 8) cur_byte = slave_cfg[63 - 8*rd_cmd_cnt -: 8];
          rd_cmd_cnt++;
          ack_acc = {ack_acc[6:0], m_ack_in};
        end
        if (m_stop) begin
          stop_cnt++;
          stop_cycle = cyc;
        end
        if (!hold) begin
          @(negedge clk);
          @(negedge clk);
          m_done = 1'b1; m_ack_err = nack; m_data_out = cur_byte;
          if (is_rd && (m_ack_in !== ack_exp)) ack_unstable++;
          @(posedge clk);
          #1;
          m_done = 1'b0; m_ack_err = 1'b0;
        end
      end
    end
  end

  // Output monitor: read bytes, done pulses, busy/done overlap.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rv_cnt++;
        rd_acc   = {rd_acc[55:0], rd_data};
        last_acc = {last_acc[6:0], rd_last};
      end
      if (done) begin
        done_cnt++;
        err_at_done = err;
        if (busy) busy_bad++;
      end
    end
  end

  task automatic launch(input int i);
    op = tbl[i].op; dev_addr = tbl[i].dev; reg_addr = tbl[i].rg;
    wdata = tbl[i].wd; rd_len = tbl[i].len;
    nack_cfg = tbl[i].nack_at; slave_cfg = tbl[i].slave;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_vec(input int i);
    string p;
    p = $sformatf("v%0d_", i);
    check({p, "wr_cnt"},    64'(wr_cnt),     64'(tbl[i].exp_wr));
    check({p, "wr_bytes"},  64'(wr_acc),     64'(tbl[i].exp_wr_acc));
    check({p, "starts"},    64'(start_acc),  64'(tbl[i].exp_start));
    check({p, "rd_cmds"},   64'(rd_cmd_cnt), 64'(tbl[i].exp_rd));
    check({p, "rd_valids"}, 64'(rv_cnt),     64'(tbl[i].exp_rd));
    check({p, "rd_data"},   rd_acc,          tbl[i].exp_rd_acc);
    check({p, "ack_in"},    64'(ack_acc),    64'(tbl[i].exp_ack));
    check({p, "rd_last"},   64'(last_acc),   64'(tbl[i].exp_last));
    check({p, "stops"},     64'(stop_cnt),   64'd1);
    check({p, "done_cnt"},  64'(done_cnt),   64'd1);
    check({p, "err"},       64'(err_at_done), 64'(tbl[i].exp_err));
    check({p, "ack_stable"}, 64'(ack_unstable), 64'd0);
    check({p, "busy_done"}, 64'(busy_bad),   64'd0);
    repeat (4) @(negedge clk);
    check({p, "err_held"},  64'(err),        64'(tbl[i].exp_err));
    check({p, "idle"},      64'(busy),       64'd0);
  endtask

  initial begin : stimulus
    int n;
    //          op   dev    reg    wd     len   nack slave                   wr  wr_acc      st      rd  rd_acc                  ack     last    err
    tbl[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 3'd0, 0, 64'h0,                   3, 24'hA010A5, 3'b100, 0, 64'h0,                   8'h00, 8'h00, 2'b00};
    tbl[1] = '{1'b1, 7'h50, 8'h00, 8'h00, 3'd2, 0, 64'h1122330000000000,    3, 24'hA000A1, 3'b101, 3, 64'h112233,              8'h01, 8'h01, 2'b00};
    tbl[2] = '{1'b1, 7'h50, 8'h00, 8'h00, 3'd2, 1, 64'h1122330000000000,    1, 24'h0000A0, 3'b001, 0, 64'h0,                   8'h00, 8'h00, 2'b01};
    tbl[3] = '{1'b0, 7'h3C, 8'hFF, 8'h00, 3'd0, 3, 64'h0,                   3, 24'h78FF00, 3'b100, 0, 64'h0,                   8'h00, 8'h00, 2'b01};
    tbl[4] = '{1'b1, 7'h7F, 8'h80, 8'h00, 3'd0, 0, 64'h5A00000000000000,    3, 24'hFE80FF, 3'b101, 1, 64'h5A,                  8'h01, 8'h01, 2'b00};
    tbl[5] = '{1'b1, 7'h01, 8'h20, 8'h00, 3'd7, 0, 64'h0102030405060708,    3, 24'h022003, 3'b101, 8, 64'h0102030405060708,    8'h01, 8'h01, 2'b00};
    tbl[6] = '{1'b1, 7'h22, 8'h05, 8'h00, 3'd1, 3, 64'h0,                   3, 24'h440545, 3'b101, 0, 64'h0,                   8'h00, 8'h00, 2'b01};

    reset = 1'b0; req = 1'b0; op = 1'b0; dev_addr = '0; reg_addr = '0;
    wdata = '0; rd_len = '0; m_busy = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transactions.
    for (int i = 0; i < NVEC; i++) begin
      clear_logs();
      launch(i);
      wait_done(400);
      check_vec(i);
    end

    // Spurious m_done while idle must not start anything.
    clear_logs();
    @(negedge clk); m_done = 1'b1;
    @(negedge clk); m_done = 1'b0;
    repeat (4) @(negedge clk);
    check("spurious_done_cmds", 64'(wr_cnt + rd_cmd_cnt + stop_cnt), 64'd0);
    check("spurious_done_busy", 64'(busy), 64'd0);

    // req while busy is ignored; latched fields survive input changes.
    clear_logs();
    launch(0);
    repeat (3) @(negedge clk);
    op = 1'b1; dev_addr = 7'h11; reg_addr = 8'h22; wdata = 8'h33; rd_len = 3'd5;
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_done(400);
    check("busy_req_wr_cnt", 64'(wr_cnt), 64'd3);
    check("busy_req_bytes",  64'(wr_acc), 64'hA010A5);
    check("busy_req_reads",  64'(rd_cmd_cnt), 64'd0);
    check("busy_req_done",   64'(done_cnt), 64'd1);
    repeat (6) @(negedge clk);
    check("busy_req_no_retrigger", 64'(wr_cnt + stop_cnt), 64'd4);

    // req while the master bus is busy is ignored.
    clear_logs();
    m_busy = 1'b1;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (8) @(negedge clk);
    check("mbusy_req_cmds", 64'(wr_cnt + rd_cmd_cnt + stop_cnt), 64'd0);
    check("mbusy_req_busy", 64'(busy), 64'd0);
    m_busy = 1'b0;

    // Reset in the middle of a burst read: outputs clear at once, no STOP.
    clear_logs();
    launch(5);
    n = 0;
    while (rd_cmd_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midread_reached", 64'(rd_cmd_cnt >= 2), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("midread_reset_outputs", outs(), 64'd0);
    repeat (3) @(negedge clk);
    check("midread_no_stop", 64'(stop_cnt), 64'd0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("after_reset_idle", outs(), 64'd0);
    clear_logs();
    launch(0);
    wait_done(400);
    check_vec(0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Withhold m_done after the REG byte: watchdog aborts to STOP with err=10.
    clear_logs();
    withhold_cfg = 2;
    launch(0);
    wait_done(400);
    withhold_cfg = 0;
    check("to_wr_cnt",   64'(wr_cnt), 64'd2);
    check("to_stop_cnt", 64'(stop_cnt), 64'd1);
    check("to_stop_lat", 64'(stop_cycle - reg_cycle), 64'd51);
    check("to_err",      64'(err_at_done), 64'(2'b10));
    check("to_done",     64'(done_cnt), 64'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
